// File: rtl/ma_pkg.sv
// ============================================================================
// Module   : ma_pkg
// Purpose  : Shared widths, defaults and FSM encodings for the MA sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ma_pkg;

    localparam int DATA_LENGTH_DEF  = 8;
    localparam int MESH_LENGTH_DEF  = 16;
    localparam int ACC_LENGTH_DEF   = 32;
    localparam int FIFO_DEPTH_DEF   = 4;
    localparam int WAIT_TIMEOUT_DEF = 64;

    localparam int IN_W  = DATA_LENGTH_DEF * MESH_LENGTH_DEF;
    localparam int OUT_W = ACC_LENGTH_DEF * MESH_LENGTH_DEF;
    localparam int CNT_W = 16;

    // Credits must be able to hold the full FIFO depth, hence depth+1 values.
    function automatic int cred_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CRED_W = cred_width(FIFO_DEPTH_DEF);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_WAIT_W = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/ma_result_fifo.sv
// ============================================================================
// Module   : ma_result_fifo
// Purpose  : First-word-fall-through result FIFO with full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ma_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/ma_sequencer.sv
// ============================================================================
// Module   : ma_sequencer
// Purpose  : Tile sequencer for the systolic MA: weight load, image stream, result buffering.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ma_sequencer
    import ma_pkg::*;
#(
    parameter int DATA_LENGTH  = DATA_LENGTH_DEF,
    parameter int MESH_LENGTH  = MESH_LENGTH_DEF,
    parameter int ACC_LENGTH   = ACC_LENGTH_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [CNT_W-1:0]                    cfg_num_rows,
    input  logic                                w_valid,
    output logic                                w_ready,
    input  logic [DATA_LENGTH*MESH_LENGTH-1:0]  w_data,
    input  logic                                i_valid,
    output logic                                i_ready,
    input  logic [DATA_LENGTH*MESH_LENGTH-1:0]  i_data,
    output logic [DATA_LENGTH*MESH_LENGTH-1:0]  ma_weight,
    output logic                                ma_weight_load,
    output logic [DATA_LENGTH*MESH_LENGTH-1:0]  ma_image,
    output logic                                ma_image_load,
    input  logic                                ma_out_valid_weight,
    input  logic                                ma_out_valid_image,
    input  logic [ACC_LENGTH*MESH_LENGTH-1:0]   ma_out_data,
    output logic                                r_valid,
    input  logic                                r_ready,
    output logic [ACC_LENGTH*MESH_LENGTH-1:0]   r_data,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);

    localparam int OUT_BITS  = ACC_LENGTH * MESH_LENGTH;
    localparam int CRED_BITS = cred_width(FIFO_DEPTH);
    localparam int WCNT_BITS = $clog2(MESH_LENGTH + 1);
    localparam int WD_BITS   = $clog2(WAIT_TIMEOUT + 1);

    logic [2:0]           state;
    logic [CNT_W-1:0]     rows_cfg;
    logic [CNT_W-1:0]     issued;
    logic [CNT_W-1:0]     popped;
    logic [WCNT_BITS-1:0] w_cnt;
    logic [WD_BITS-1:0]   wd_cnt;
    logic [CRED_BITS-1:0] credits;
    logic                 w_fire;
    logic                 i_fire;
    logic                 push;
    logic                 pop;
    logic                 overflow;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign busy     = (state != ST_IDLE);
    assign w_ready  = (state == ST_LOAD_W);
    assign i_ready  = (state == ST_STREAM) && (credits != '0) && (issued < rows_cfg);
    assign done     = (state == ST_DRAIN) && (popped == rows_cfg);
    assign w_fire   = w_valid && w_ready;
    assign i_fire   = i_valid && i_ready;
    assign r_valid  = !fifo_empty;
    assign pop      = r_valid && r_ready;
    assign push     = ma_out_valid_image && (state != ST_IDLE);
    assign overflow = push && fifo_full && !pop;

    ma_result_fifo #(
        .WIDTH (OUT_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (ma_out_data),
        .pop       (pop),
        .pop_data  (r_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            rows_cfg       <= '0;
            issued         <= '0;
            popped         <= '0;
            w_cnt          <= '0;
            wd_cnt         <= '0;
            credits        <= CRED_BITS'(FIFO_DEPTH);
            ma_weight      <= '0;
            ma_weight_load <= 1'b0;
            ma_image       <= '0;
            ma_image_load  <= 1'b0;
            err            <= 1'b0;
        end else begin
            // One credit per image row in flight or buffered; returned on consumer pop.
            if (i_fire && !pop)
                credits <= credits - 1'b1;
            else if (pop && !i_fire)
                credits <= credits + 1'b1;

            ma_weight_load <= w_fire;
            if (w_fire) ma_weight <= w_data;
            ma_image_load <= i_fire;
            if (i_fire) ma_image <= i_data;

            if (overflow) err <= 1'b1;
            if (pop && state != ST_IDLE) popped <= popped + CNT_W'(1);

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rows_cfg <= cfg_num_rows;
                        err      <= 1'b0;
                        w_cnt    <= '0;
                        issued   <= '0;
                        popped   <= '0;
                        state    <= ST_LOAD_W;
                    end
                end
                ST_LOAD_W: begin
                    if (w_fire) begin
                        w_cnt <= w_cnt + 1'b1;
                        if (w_cnt == WCNT_BITS'(MESH_LENGTH - 1)) begin
                            wd_cnt <= '0;
                            state  <= ST_WAIT_W;
                        end
                    end
                end
                ST_WAIT_W: begin
                    if (ma_out_valid_weight) begin
                        state <= (rows_cfg == '0) ? ST_DRAIN : ST_STREAM;
                    end else if (wd_cnt == WD_BITS'(WAIT_TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (i_fire) begin
                        issued <= issued + CNT_W'(1);
                        if (issued == rows_cfg - CNT_W'(1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ma_sequencer.sv
// ============================================================================
// Module   : tb_ma_sequencer
// Purpose  : Directed self-checking bench for ma_sequencer with a small MA model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ma_sequencer;

    localparam int IW   = 128;
    localparam int OW   = 512;
    localparam int MESH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   cfg_num_rows;
    logic          w_valid;
    logic          w_ready;
    logic [IW-1:0] w_data = {MESH{8'h11}};
    logic          i_valid;
    logic          i_ready;
    logic [IW-1:0] i_data = {4{32'h1000_0001}};
    logic [IW-1:0] ma_weight;
    logic          ma_weight_load;
    logic [IW-1:0] ma_image;
    logic          ma_image_load;
    logic          ma_out_valid_weight = 1'b0;
    logic          ma_out_valid_image  = 1'b0;
    logic [OW-1:0] ma_out_data = '0;
    logic          r_valid;
    logic          r_ready;
    logic [OW-1:0] r_data;
    logic          busy;
    logic          done;
    logic          err;

    ma_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .cfg_num_rows        (cfg_num_rows),
        .w_valid             (w_valid),
        .w_ready             (w_ready),
        .w_data              (w_data),
        .i_valid             (i_valid),
        .i_ready             (i_ready),
        .i_data              (i_data),
        .ma_weight           (ma_weight),
        .ma_weight_load      (ma_weight_load),
        .ma_image            (ma_image),
        .ma_image_load       (ma_image_load),
        .ma_out_valid_weight (ma_out_valid_weight),
        .ma_out_valid_image  (ma_out_valid_image),
        .ma_out_data         (ma_out_data),
        .r_valid             (r_valid),
        .r_ready             (r_ready),
        .r_data              (r_data),
        .busy                (busy),
        .done                (done),
        .err                 (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor / source / MA model state, written only by the negedge process.
    int cyc = 0, n_wfire = 0, n_wl = 0, wl_run = 0, wl_max = 0;
    int n_ifire = 0, n_il = 0, n_pop = 0, n_done = 0, n_irdy = 0;
    int err_rise_cyc = 0, last_wfire_cyc = 0, ack_cyc = 0, done_cyc = 0, ack_cd = 0;
    logic          prev_err = 1'b0, adv_w = 1'b0, adv_i = 1'b0;
    logic [7:0]    w_tag = 8'h11;
    logic [31:0]   i_tag = 32'h1000_0001;
    logic [IW-1:0] last_w = '0, last_i = '0;
    logic [31:0]   exp_q [$];
    logic [31:0]   t;
    logic          pv [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0]   pd [3] = '{32'h0, 32'h0, 32'h0};
    // Written by the main sequence only.
    int wl_base = 0, pop_base = 0;
    logic ack_en = 1'b0;

    always @(negedge clk) begin
        cyc++;
        // Source data advances only after the handshake edge has passed.
        if (adv_w) begin w_tag++; w_data = {MESH{w_tag}}; adv_w = 1'b0; end
        if (adv_i) begin i_tag++; i_data = {4{i_tag}}; adv_i = 1'b0; end
        if (rst) begin
            exp_q.delete();
            pv = '{1'b0, 1'b0, 1'b0};
            ma_out_valid_image  = 1'b0;
            ma_out_valid_weight = 1'b0;
            ack_cd   = 0;
            prev_err = 1'b0;
            wl_run   = 0;
        end else begin
            if (ma_weight_load) begin
                check_eq("ma_weight", ma_weight, last_w);
                n_wl++; wl_run++;
                if (wl_run > wl_max) wl_max = wl_run;
            end else wl_run = 0;
            if (ma_image_load) begin
                check_eq("ma_image", ma_image, last_i);
                n_il++;
            end
            if (w_valid && w_ready) begin
                n_wfire++; last_w = w_data; last_wfire_cyc = cyc; adv_w = 1'b1;
            end
            if (i_valid && i_ready) begin
                n_ifire++; last_i = i_data; exp_q.push_back(i_tag); adv_i = 1'b1;
            end
            if (i_ready) n_irdy++;
            if (r_valid && r_ready) begin
                n_pop++;
                if (exp_q.size() == 0) check_eq("pop_unexpected", 1, 0);
                else begin
                    t = exp_q.pop_front();
                    check_eq("r_data_order", r_data, {MESH{t}});
                end
            end
            if (done) begin
                n_done++; done_cyc = cyc;
                check_eq("done_after_pops", n_pop - pop_base, cfg_num_rows);
            end
            if (err && !prev_err) err_rise_cyc = cyc;
            prev_err = err;
            // Weight-loaded acknowledge two cycles after the 16th weight load.
            ma_out_valid_weight = (ack_cd == 1);
            if (ma_out_valid_weight) ack_cyc = cyc;
            if (ack_cd > 0) ack_cd--;
            if (ma_weight_load && ack_en && (n_wl - wl_base == MESH)) ack_cd = 2;
            // Three-cycle MA image pipeline; result = image tag replicated per column.
            ma_out_valid_image = pv[2];
            ma_out_data        = {MESH{pd[2]}};
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = ma_image_load; pd[0] = ma_image[31:0];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tile_start(input logic [15:0] rows);
        cfg_num_rows = rows;
        wl_base  = n_wl;
        pop_base = n_pop;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int b;
        bit seen;
        b = n_done;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            step(1);
            if (n_done != b) seen = 1'b1;
        end
        if (!seen) check_eq(tag, 0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, {busy, done, err, w_ready, i_ready, r_valid, ma_weight_load, ma_image_load}, 0);
    endtask

    int bw, bi, bp, bd, bir, bif;
    bit seen;

    initial begin
        rst = 1'b1; start = 1'b0; cfg_num_rows = '0;
        w_valid = 1'b0; i_valid = 1'b0; r_ready = 1'b0;

        // Reset held with random inputs.
        for (int k = 0; k < 6; k++) begin
            start = 1'($urandom); w_valid = 1'($urandom); i_valid = 1'($urandom);
            r_ready = 1'($urandom); cfg_num_rows = 16'($urandom);
            step(1);
            if (k == 2 || k == 5) check_idle_outputs("reset_outputs");
        end
        check_eq("reset_r_data", r_data, 0);
        start = 1'b0; w_valid = 1'b0; i_valid = 1'b0; r_ready = 1'b0;
        rst = 1'b0;
        step(2);

        // Basic tile: 3 rows, everything flowing.
        w_valid = 1'b1; i_valid = 1'b1; r_ready = 1'b1; ack_en = 1'b1;
        bw = n_wfire; bi = n_il; bp = n_pop; bd = n_done;
        tile_start(16'd3);
        wait_done(300, "basic_done_timeout");
        step(3);
        check_eq("basic_w_handshakes", n_wfire - bw, 16);
        check_eq("basic_weight_loads", n_wl - wl_base, 16);
        check_eq("basic_weight_contig", wl_max, 16);
        check_eq("basic_image_loads", n_il - bi, 3);
        check_eq("basic_pops", n_pop - bp, 3);
        check_eq("basic_done_count", n_done - bd, 1);
        check_eq("basic_err_busy", {err, busy}, 0);

        // Backpressure: FIFO depth 4 limits issue while consumer stalls.
        r_ready = 1'b0;
        bi = n_il; bp = n_pop; bd = n_done;
        tile_start(16'd10);
        step(60);
        check_eq("bp_issued_before_ready", n_il - bi, 4);
        check_eq("bp_i_ready_low", i_ready, 0);
        check_eq("bp_r_valid_busy", {r_valid, busy}, 2'b11);
        r_ready = 1'b1;
        wait_done(300, "bp_done_timeout");
        step(2);
        check_eq("bp_issued_total", n_il - bi, 10);
        check_eq("bp_pops", n_pop - bp, 10);
        check_eq("bp_done_err", {n_done - bd == 1, err}, 2'b10);

        // Zero rows: done one cycle after the weight acknowledge.
        bw = n_wfire; bir = n_irdy; bd = n_done;
        tile_start(16'd0);
        wait_done(100, "zero_done_timeout");
        step(2);
        check_eq("zero_w_handshakes", n_wfire - bw, 16);
        check_eq("zero_i_ready_cycles", n_irdy - bir, 0);
        check_eq("zero_done_latency", done_cyc - ack_cyc, 1);
        check_eq("zero_done_count", n_done - bd, 1);

        // Timeout: no acknowledge. WAIT_W is entered at the edge closing the last
        // weight-handshake cycle; err becomes visible 64 edges later, i.e. 65 samples on.
        ack_en = 1'b0;
        bd = n_done;
        tile_start(16'd2);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            step(1);
            if (err) seen = 1'b1;
        end
        if (!seen) check_eq("timeout_err_never", 0, 1);
        step(1);
        check_eq("timeout_latency", err_rise_cyc - last_wfire_cyc, 65);
        check_eq("timeout_state", {err, busy}, 2'b10);
        check_eq("timeout_no_done", n_done - bd, 0);
        ack_en = 1'b1;
        tile_start(16'd1);
        check_eq("start_clears_err", {err, busy}, 2'b01);
        wait_done(200, "after_timeout_done_timeout");
        step(2);

        // Abort mid-stream with an ignored start beforehand.
        i_valid = 1'b0; r_ready = 1'b1;
        bif = n_ifire; bd = n_done;
        tile_start(16'd10);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step(1);
            if (i_ready) seen = 1'b1;
        end
        if (!seen) check_eq("abort_stream_never", 0, 1);
        start = 1'b1; cfg_num_rows = 16'd7;
        step(3);
        start = 1'b0; cfg_num_rows = 16'd10;
        check_eq("abort_start_ignored_busy", busy, 1);
        i_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            step(1);
            if (n_ifire - bif >= 5) seen = 1'b1;
        end
        if (!seen) check_eq("abort_five_rows_never", 0, 1);
        i_valid = 1'b0;
        check_eq("abort_rows_before_reset", n_ifire - bif, 5);
        rst = 1'b1;
        #1;
        check_idle_outputs("abort_reset_outputs");
        step(1);
        check_eq("abort_reset_data", {ma_weight, ma_image, r_data[255:0]}, 0);
        rst = 1'b0;
        step(5);
        check_idle_outputs("abort_after_reset");
        check_eq("abort_no_done", n_done - bd, 0);

        i_valid = 1'b1;
        bi = n_il; bp = n_pop; bd = n_done;
        tile_start(16'd2);
        wait_done(200, "abort_restart_done_timeout");
        step(2);
        check_eq("restart_image_loads", n_il - bi, 2);
        check_eq("restart_pops", n_pop - bp, 2);
        check_eq("restart_done_err", {n_done - bd == 1, err, busy}, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ma_sequencer.md
Name: ma_sequencer

Overview:
- Controller in front of the weight-stationary systolic matrix unit (MA); sequences one tile per start.
- Per tile: loads mesh_length weight rows, waits for the MA weight-loaded acknowledge, then streams cfg_num_rows image rows.
- Buffers MA results in a credit-managed FIFO, because the MA has no output backpressure.
- Sits between the on-chip weight/image buffers (valid/ready sources), the MA, and the result consumer (valid/ready sink).

Parameters:
- data_length, 8, bits per mesh element.
- mesh_length, 16, PE rows/columns; weight rows per tile.
- acc_length, 32, accumulator width per output column.
- fifo_depth, 4, result FIFO entries (power of two, at least 2).
- wait_timeout, 64, maximum cycles in WAIT_W before error.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  tile start request; sampled only in IDLE
- cfg_num_rows  in  16  image rows for this tile; latched at start
- w_valid  in  1  weight row valid
- w_ready  out  1  weight row accepted
- w_data  in  data_length*mesh_length  weight row
- i_valid  in  1  image row valid
- i_ready  out  1  image row accepted
- i_data  in  data_length*mesh_length  image row
- ma_weight  out  data_length*mesh_length  to MA in_weight
- ma_weight_load  out  1  to MA in_weight_load
- ma_image  out  data_length*mesh_length  to MA in_image
- ma_image_load  out  1  to MA in_image_load
- ma_out_valid_weight  in  1  MA weight-loaded pulse
- ma_out_valid_image  in  1  MA result-row valid
- ma_out_data  in  acc_length*mesh_length  MA result row
- r_valid  out  1  result row valid
- r_ready  in  1  consumer accepts result
- r_data  out  acc_length*mesh_length  result row
- busy  out  1  tile in progress
- done  out  1  one-cycle pulse at tile completion
- err  out  1  sticky weight-acknowledge timeout flag

Behaviour:
- Reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - While rst is high, all outputs are 0, the FSM is in IDLE, the FIFO is emptied and all counters are cleared.
  - Reset mid-tile aborts the tile. No done pulse. Buffered results are discarded.
- FSM states: IDLE, LOAD_W, WAIT_W, STREAM, DRAIN.
- IDLE:
  - busy=0.
  - On start=1: latch cfg_num_rows, clear err, go to LOAD_W on the next cycle.
- start outside IDLE is ignored.
- LOAD_W:
  - w_ready=1 until mesh_length beats have been accepted.
  - Each accepted beat registers w_data into ma_weight and asserts ma_weight_load the following cycle (1-cycle latency).
  - Gaps in w_valid produce gaps in ma_weight_load.
  - After the mesh_length-th beat, go to WAIT_W.
- WAIT_W:
  - On ma_out_valid_weight=1: go to STREAM, or to DRAIN if the latched row count is 0.
  - Watchdog counts cycles in WAIT_W. When it reaches wait_timeout: set err=1, return to IDLE, no done pulse.
  - ma_out_valid_weight in any other state is ignored.
- STREAM:
  - i_ready = (credits > 0) and (rows issued < latched rows).
  - Each accepted beat registers i_data into ma_image and asserts ma_image_load the next cycle.
  - When rows issued = latched rows, go to DRAIN.
- Credits:
  - Reset value is fifo_depth.
  - Decrement on each image issue; increment on each FIFO pop (r_valid & r_ready). A same-cycle issue and pop leaves credits unchanged.
  - Credits guarantee the FIFO never overflows. A push while full is a design error: set err, drop the data.
- FIFO:
  - Push on ma_out_valid_image, in any non-IDLE state.
  - r_valid = not empty; r_data = head entry (first-word-fall-through).
  - Order is preserved.
- DRAIN:
  - When results popped = latched rows: done=1 for one cycle, busy=0, return to IDLE.
- busy=1 in LOAD_W, WAIT_W, STREAM and DRAIN.
- Row and pop counters are 16 bits. cfg_num_rows=65535 is legal; no wrap within a tile.

Decomposition:
- Shared package/include ma_pkg holds:
  - FSM state encodings.
  - Derived widths: IN_W = data_length*mesh_length, OUT_W = acc_length*mesh_length, CNT_W = 16, credit width = clog2(fifo_depth+1).
- One sub-module: ma_result_fifo, a synchronous FWFT FIFO with parameters width and depth, async active-high reset, and full/empty flags.

Test Plan:
- Reset: hold rst=1 with random inputs -> busy, done, err, w_ready, i_ready, r_valid, ma_weight_load and ma_image_load are all 0.
- Basic tile: start with cfg_num_rows=3, sources always valid, r_ready=1, MA ack 2 cycles after the last weight load -> exactly 16 w handshakes, ma_weight_load high 16 contiguous cycles, then 3 image loads, 3 results in push order, done exactly once after the 3rd pop.
- Backpressure: cfg_num_rows=10, fifo_depth=4, r_ready=0 -> exactly 4 image rows issued, then i_ready=0. Raise r_ready -> remaining 6 rows issued, 10 results in order, no err.
- Zero rows: cfg_num_rows=0 -> 16 weight beats, i_ready never 1, done 1 cycle after ma_out_valid_weight.
- Timeout: never assert ma_out_valid_weight -> err=1 exactly 64 cycles after entering WAIT_W, FSM in IDLE, no done. Next start clears err.
- Abort: pulse rst after 5 of 10 image rows, with start asserted during STREAM beforehand (ignored) -> all outputs 0, FIFO empty. A following start with cfg_num_rows=2 completes normally with 2 results.
